// File: rtl/seg7_multi_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_multi_display
//  Description : Multi-digit seven-segment controller. Accepts a binary value
//                over valid/ready, converts it to BCD with a bit-serial
//                double-dabble engine (or passes it through as hex), and
//                drives NUM_DIGITS active-low gfedcba segment groups with
//                optional leading-zero blanking and overflow dashes.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_multi_display #(
   parameter int NUM_DIGITS = 6,
   parameter int BIN_W      = 20
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BIN_W-1:0]        in_value,
   input  logic                    in_hex,
   input  logic                    in_blank_lz,
   output logic [7*NUM_DIGITS-1:0] leds,
   output logic                    overflow,
   output logic                    done
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   // Segment code for a dash: only segment g lit (active-low)
   localparam logic [6:0] DASH_N = 7'b0111111;
   localparam logic [6:0] OFF_N  = 7'b1111111;

   // 10**n evaluated at elaboration; fits 64 bits for every legal digit count
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int j = 0; j < n; j++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

   // Active-high gfedcba pattern for one hex digit
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b0111111;
         4'h1:    s = 7'b0000110;
         4'h2:    s = 7'b1011011;
         4'h3:    s = 7'b1001111;
         4'h4:    s = 7'b1100110;
         4'h5:    s = 7'b1101101;
         4'h6:    s = 7'b1111101;
         4'h7:    s = 7'b0000111;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1101111;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b1111100;
         4'hC:    s = 7'b0111001;
         4'hD:    s = 7'b1011110;
         4'hE:    s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      UPDATE  = 2'd2
   } state_t;

   state_t             state;
   logic [BIN_W-1:0]   value_r;
   logic               hex_r;
   logic               blank_r;
   logic               ovf_r;
   logic [BCD_W-1:0]   bcd;
   logic [CNT_W-1:0]   cnt;

   logic [63:0]        in_ext;
   logic               ovf_at_xfer;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   hex_src;
   logic [7*NUM_DIGITS-1:0] leds_next;

   assign in_ext = 64'(in_value);

   // Range check done on the incoming value so it is ready when latched
   always_comb begin
      if (in_hex) begin
         ovf_at_xfer = (in_ext >> BCD_W) != 64'd0;
      end else begin
         ovf_at_xfer = in_ext >= DEC_LIMIT;
      end
   end

   // Double-dabble correction: bias every nibble >= 5 before the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Hex digit source sized to the display, truncating or zero-extending
   generate
      if (BIN_W >= BCD_W) begin : g_hex_trunc
         assign hex_src = value_r[BCD_W-1:0];
      end else begin : g_hex_ext
         assign hex_src = {{(BCD_W - BIN_W){1'b0}}, value_r};
      end
   endgenerate

   // Segment image: dashes on overflow, else decoded digits with blanking
   always_comb begin
      logic [3:0] nib;
      logic       zero_above;
      nib        = 4'd0;
      zero_above = 1'b1;
      leds_next  = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nib = hex_r ? hex_src[4*i +: 4] : bcd[4*i +: 4];
         if (nib != 4'd0) begin
            zero_above = 1'b0;
         end
         if (ovf_r) begin
            leds_next[7*i +: 7] = DASH_N;
         end else if (blank_r && (i != 0) && zero_above) begin
            leds_next[7*i +: 7] = OFF_N;
         end else begin
            leds_next[7*i +: 7] = ~seg_of(nib);
         end
      end
   end

   // Control FSM: accept, convert bit-serially, then publish the display
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         in_ready <= 1'b1;
         done     <= 1'b0;
         overflow <= 1'b0;
         leds     <= '1;
         value_r  <= '0;
         hex_r    <= 1'b0;
         blank_r  <= 1'b0;
         ovf_r    <= 1'b0;
         bcd      <= '0;
         cnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  value_r  <= in_value;
                  hex_r    <= in_hex;
                  blank_r  <= in_blank_lz;
                  ovf_r    <= ovf_at_xfer;
                  in_ready <= 1'b0;
                  if (in_hex) begin
                     state <= UPDATE;
                  end else begin
                     bcd   <= '0;
                     cnt   <= '0;
                     state <= CONVERT;
                  end
               end
            end
            CONVERT: begin
               bcd     <= {bcd_adj[BCD_W-2:0], value_r[BIN_W-1]};
               value_r <= value_r << 1;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               leds     <= leds_next;
               overflow <= ovf_r;
               done     <= 1'b1;
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_multi_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_multi_display
//  Description : Self-checking bench for seg7_multi_display with directed
//                cases and randomized transfers against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_multi_display;

   localparam int ND = 6;
   localparam int BW = 20;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_hex = 1'b0;
   logic            in_blank_lz = 1'b0;
   logic [BW-1:0]   in_value = '0;
   logic            in_ready;
   logic            overflow;
   logic            done;
   logic [7*ND-1:0] leds;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_multi_display #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .in_hex     (in_hex),
      .in_blank_lz(in_blank_lz),
      .leds       (leds),
      .overflow   (overflow),
      .done       (done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
         3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
         6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
         9: return 7'b1101111; 10: return 7'b1110111; 11: return 7'b1111100;
        12: return 7'b0111001; 13: return 7'b1011110; 14: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   function automatic longint unsigned ipow(input longint unsigned b, input int e);
      longint unsigned r = 1;
      for (int j = 0; j < e; j++) r = r * b;
      return r;
   endfunction

   function automatic bit model_ovf(input longint unsigned v, input bit hex);
      return v >= ipow(hex ? 16 : 10, ND);
   endfunction

   // Expected display: digits by division, blank where nothing remains above
   function automatic logic [7*ND-1:0] model_leds(input longint unsigned v, input bit hex, input bit blank);
      logic [7*ND-1:0] r;
      longint unsigned base = hex ? 16 : 10;
      longint unsigned q;
      r = '1;
      for (int i = 0; i < ND; i++) begin
         q = v / ipow(base, i);
         if (model_ovf(v, hex))            r[7*i +: 7] = 7'b0111111;
         else if (blank && i > 0 && q == 0) r[7*i +: 7] = 7'b1111111;
         else                               r[7*i +: 7] = ~seg(int'(q % base));
      end
      return r;
   endfunction

   task automatic xfer(input logic [BW-1:0] v, input bit h, input bit b,
                       input bit poke, input bit hold, input string tag);
      int              lat;
      bit              rdy_low;
      logic [7*ND-1:0] exp;
      exp = model_leds(longint'(v), h, b);
      @(negedge clk);
      check({tag, ":ready_before"}, in_ready, 1);
      in_valid = 1'b1; in_value = v; in_hex = h; in_blank_lz = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_value = BW'($urandom); in_hex = 1'($urandom); in_blank_lz = 1'($urandom);
      lat = 0;
      rdy_low = 1'b1;
      while (!done && lat < 100) begin
         if (in_ready) rdy_low = 1'b0;
         if (poke) begin
            in_valid = 1'b1;
            in_value = BW'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check({tag, ":latency"}, 64'(lat), h ? 64'd1 : 64'(BW + 1));
      check({tag, ":ready_low"}, rdy_low, 1);
      check({tag, ":leds"}, leds, exp);
      check({tag, ":overflow"}, overflow, model_ovf(longint'(v), h));
      check({tag, ":ready_after"}, in_ready, 1);
      if (hold) begin
         @(posedge clk); #1;
         check({tag, ":done_pulse"}, done, 0);
         check({tag, ":leds_hold"}, leds, exp);
      end
   endtask

   initial begin
      logic [7*ND-1:0] all_off;
      bit              seen;
      logic [BW-1:0]   rv;
      all_off = '1;

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("reset:leds", leds, all_off);
      check("reset:overflow", overflow, 0);
      check("reset:done", done, 0);
      check("reset:ready", in_ready, 1);

      xfer(20'd123456, 0, 0, 0, 1, "dec123456");
      xfer(20'd42, 0, 1, 0, 1, "blank42");
      xfer(20'd0, 0, 1, 0, 1, "blank0");
      xfer(20'd42, 0, 0, 0, 1, "noblank42");
      xfer(20'hABCDE, 1, 0, 0, 1, "hexABCDE");
      xfer(20'h000F0, 1, 1, 0, 1, "hexblank");
      xfer(20'd1000000, 0, 1, 0, 1, "ovf1000000");
      xfer(20'd999999, 0, 0, 0, 1, "dec999999");
      xfer(20'd5555, 0, 1, 1, 1, "ignore_valid");

      // Abort a conversion partway through with an asynchronous reset
      @(negedge clk);
      in_valid = 1'b1; in_value = 20'd123456; in_hex = 1'b0; in_blank_lz = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort:leds", leds, all_off);
      check("abort:done", done, 0);
      check("abort:ready", in_ready, 1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("abort:no_done", seen, 0);
      check("abort:leds_after", leds, all_off);
      xfer(20'd7, 0, 0, 0, 1, "after_abort7");

      // Randomized transfers, alternating held and back-to-back issue
      for (int n = 0; n < 40; n++) begin
         case ($urandom % 3)
            0:       rv = BW'($urandom_range(0, 999));
            1:       rv = BW'($urandom);
            default: rv = BW'($urandom_range(999990, 1000010));
         endcase
         xfer(rv, ($urandom % 4) == 0, 1'($urandom), 1'($urandom), n[0], "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_multi_display.md
# seg7_multi_display

Parametrised multi-digit seven-segment display controller for the DE1-SoC HEX bank. Accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine (one input bit per cycle), or displays it directly in hexadecimal. It then drives NUM_DIGITS active-low segment groups, with optional leading-zero blanking and overflow indication. It replaces per-digit combinational decoders fed by external BCD logic.

## Interface

- NUM_DIGITS, 6: number of digits driven; legal range 1–8.
- BIN_W, 20: input value width; legal range 4–32.
- clk, in, 1: system clock; all state updates on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset; removal synchronous to clk.
- in_valid, in, 1: in_value/in_hex/in_blank_lz valid.
- in_ready, out, 1: block can accept; a transfer occurs on a rising edge with in_valid && in_ready.
- in_value, in, BIN_W: value to display.
- in_hex, in, 1: 1 = hex mode, 0 = decimal mode; sampled at transfer.
- in_blank_lz, in, 1: 1 = blank leading zeros; sampled at transfer.
- leds, out, 7*NUM_DIGITS: segments, active-low; digit i at bits [7i+6:7i], digit 0 least significant; bit order within digit gfedcba (bit 6 = g).
- overflow, out, 1: registered; high while the displayed value did not fit.
- done, out, 1: one-cycle pulse, high in the first cycle that new leds are visible.

## Operation

- FSM states: IDLE, CONVERT, UPDATE.
- IDLE:
  - in_ready = 1.
  - On transfer, latch value, mode, and blank flag.
  - Decimal: clear the BCD register (4*NUM_DIGITS bits) and the bit counter, then go to CONVERT.
  - Hex: go to UPDATE.
- CONVERT:
  - in_ready = 0.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, value} left one bit.
  - Runs exactly BIN_W cycles, then goes to UPDATE.
- UPDATE:
  - in_ready = 0.
  - Load the leds register and overflow, then return to IDLE.
- Overflow:
  - Decimal: latched value >= 10**NUM_DIGITS.
  - Hex: any latched bit at index >= 4*NUM_DIGITS is set.
  - The comparison is made at transfer.
  - On overflow, every digit shows '-' (7'b0111111) and overflow = 1; otherwise overflow = 0.
- Digit nibble source:
  - Hex: value[4i+3:4i].
  - Decimal: BCD nibble i.
- Segment patterns (active-high gfedcba, then inverted onto leds):
  - 0 0111111, 1 0000110, 2 1011011, 3 1001111, 4 1100110.
  - 5 1101101, 6 1111101, 7 0000111, 8 1111111, 9 1101111.
  - A 1110111, b 1111100, C 0111001, d 1011110, E 1111001, F 1110001.
- Leading-zero blanking:
  - When the latched blank flag is set, digit i (i >= 1) shows all-off (7'b1111111) if it and every higher digit are zero.
  - Digit 0 is never blanked; value 0 shows a single '0'.
  - Blanking does not apply on overflow.
- in_valid while in_ready = 0 is ignored; no queueing. The source must hold until accepted.
- leds hold their last value between updates.

## Timing

- Reset values (asserted asynchronously):
  - leds all 1 (all digits off).
  - overflow 0, done 0, in_ready 1.
  - State IDLE; BCD register and counter cleared.
- Decimal latency, with transfer at edge k:
  - CONVERT occupies cycles k+1 .. k+BIN_W.
  - leds, overflow, and done update at edge k+BIN_W+1.
  - in_ready returns high at the same edge.
- Hex latency: leds, overflow, and done update at edge k+1; in_ready high again at edge k+1.
- Maximum throughput:
  - Decimal: one update per BIN_W+2 cycles.
  - Hex: one update per 2 cycles.
  - Back-to-back transfers are allowed on the edge in_ready returns high.
- done is high for exactly one cycle per accepted transfer.
- Reset mid-CONVERT or mid-UPDATE aborts the conversion: leds blank immediately, no done pulse, in_ready = 1 after release.
- Input changes after transfer have no effect on the display in progress.

## Test plan

- Reset: hold reset_n = 0 for 3 cycles, release -> leds all 1, overflow 0, done 0, in_ready 1.
- Decimal full: NUM_DIGITS=6, BIN_W=20, value 123456, blank_lz 0 -> done at k+21; digits 5..0 show 1,2,3,4,5,6; overflow 0; in_ready low for cycles k+1..k+20.
- Leading-zero blanking: value 42, blank_lz 1 -> digits 5..2 = 7'b1111111, digit1 = ~4, digit0 = ~2. Value 0 -> digit0 '0', others blank. Value 42 with blank_lz 0 -> 000042.
- Hex: in_hex 1, value 0xABCDE -> digits 5..0 show 0,A,b,C,d,E one cycle after transfer.
- Overflow: decimal 1000000 -> all six digits '-', overflow 1. Then decimal 999999 -> 999999 shown, overflow 0.
- Handshake and abort:
  - Assert in_valid with a different value during CONVERT -> value ignored and displayed result unchanged.
  - Assert reset_n = 0 at cycle k+10 -> leds blank, no done; after release a fresh transfer of 7 completes normally.
